prng_share_arbiter: RTL

Shares one 16-bit PRNG word stream between the masked Kyber datapath units: masked decode in poly-to-msg, masked compress, and masked CBD. It buffers incoming words in a small scrubbing FIFO and hands each word to exactly one requester through a round-robin grant. No random word is ever delivered twice or left readable after use. It sits between the PRNG core and the masked datapath blocks in the IND-CCA2 decapsulation top level.

---
 rtl/prng_arb_pkg.sv | 38 +++
 rtl/prng_arb_fifo.sv | 54 +++++
 rtl/prng_share_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/prng_arb_pkg.sv
// Shared types and helpers for the PRNG share arbiter.
// The round-robin pick works on a fixed 8-wide request vector.
package prng_arb_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } arb_state_t;

    localparam int CNT_W   = 16;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_t;

    // First set request strictly after last, wrapping modulo n.
    function automatic rr_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   last,
        input int                 n
    );
        rr_t r;
        int  j;
        r = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            j = (int'(last) + k) % n;
            if (k <= n && !r.found && req[j[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prng_arb_fifo.sv
// Scrubbing FIFO: popped slots are zeroed, flush zeroes every slot.
// No bypass; a push is only visible at the output a cycle later.
module prng_arb_fifo
    import prng_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [W-1:0]  o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + 1'b1;
            end
            if (i_pop) begin
                r_mem[r_rd] <= '0;
                r_rd        <= r_rd + 1'b1;
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/prng_share_arbiter.sv
// Round-robin sharing of one PRNG word stream across masked units.
// Optional per-requester grant counters under PRNG_ARB_STATS_EN.
module prng_share_arbiter
    import prng_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prng_valid,
    input  logic [WORD_W-1:0]        prng_data,
    output logic                     prng_ready,
    input  logic [NUM_REQ-1:0]       req,
    input  logic                     flush,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WORD_W-1:0]        rnd_data,
`ifdef PRNG_ARB_STATS_EN
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
`endif
    output logic [LVL_W-1:0]         fifo_level
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [WORD_W-1:0]   r_rnd;
    logic [IDX_W-1:0]    r_rr_last;
    logic [MAX_REQ-1:0]  w_req_x;
    rr_t                 w_pick;
    logic                w_run;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [WORD_W-1:0]   w_dout;

    assign w_run   = (r_state == ST_RUN) && !flush;
    assign w_req_x = MAX_REQ'(req);
    assign w_pick  = rr_pick(w_req_x, r_rr_last, NUM_REQ);
    assign w_push  = prng_valid && prng_ready;
    assign w_pop   = w_run && !w_empty && w_pick.found;

    assign prng_ready = w_run && !w_full;

    prng_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (prng_data),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_dout  (w_dout),
        .o_count (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FLUSH lasts one cycle unless flush stays high.
    always_comb begin
        w_state_nxt = ST_RUN;
        if (flush) begin
            w_state_nxt = ST_FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= '0;
            r_rnd     <= '0;
            r_rr_last <= IDX_W'(NUM_REQ - 1);
        end else if (w_pop) begin
            r_gnt     <= NUM_REQ'(1) << w_pick.idx;
            r_rnd     <= w_dout;
            r_rr_last <= w_pick.idx;
        end else begin
            r_gnt <= '0;
            r_rnd <= '0;
        end
    end

    assign gnt      = r_gnt;
    assign rnd_data = r_rnd;

`ifdef PRNG_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_gnt[i] && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end
`endif

endmodule
